uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- UART serializer; the transmit-side counterpart of the team's uart_rx. It produces the serial stream that uart_rx consumes on serial_in.
- Accepts one byte per handshake and emits a frame on serial_out: start bit (0), 8 data bits LSB-first, optional even-parity bit, 1 stop bit (1).
- Bit timing is derived from the same BASE_FREQ/BAUDRATE pair as the receiver, so a matched pair interoperates.

Parameters:
- BASE_FREQ, 50_000_000, clock frequency in Hz.
- BAUDRATE, 115_200, serial bit rate in bit/s.
- Derived localparam counts_per_bit = BASE_FREQ / BAUDRATE (integer division). Required to be >= 2; elaboration-time error otherwise.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- parallel_in  input  8  byte to transmit; sampled only on acceptance.
- send  input  1  request strobe/level; accepted when send=1 and ready=1 at a clk edge.
- ready  output  1  1 only in TX_IDLE; high means a new byte can be accepted.
- serial_out  output  1  registered UART line; idles high.
- tx_done  output  1  one-cycle pulse marking completion of the stop bit.

Behaviour:
- Reset (rst=0, async):
  - state=TX_IDLE; serial_out=1, ready=1, tx_done=0.
  - Baud counter, bit index and shift register all cleared.
  - Reset asserted mid-frame forces the line high immediately and abandons the frame; no tx_done is produced.
- States: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP; any other encoding returns to TX_IDLE.
- Bit timing:
  - Baud counter counts 0..counts_per_bit-1. Each bit, including start, parity and stop, holds serial_out for exactly counts_per_bit cycles.
  - The counter width is sized for counts_per_bit-1 and must not wrap early.
- TX_IDLE:
  - serial_out=1.
  - On an edge with send=1: latch parallel_in into the shift register, set serial_out=0, clear the counter, go to TX_START.
  - Start bit begins in the cycle after the acceptance edge.
- TX_START: at terminal count, drive data bit 0, set bit index to 0, go to TX_DATA.
- TX_DATA:
  - At each terminal count, advance to the next bit, LSB first.
  - After bit 7 completes, go to TX_PARITY if enabled, else drive 1 and go to TX_STOP.
- TX_PARITY: drives the parity bit; at terminal count, drive 1 and go to TX_STOP.
- TX_STOP:
  - At terminal count, go to TX_IDLE; tx_done=1 for exactly that one following cycle, in which ready=1 again.
- Frame length: 10*counts_per_bit cycles, or 11*counts_per_bit with parity, measured from the acceptance edge to the edge where tx_done rises.
- Handshake rules:
  - send while ready=0 is ignored and never queued.
  - parallel_in changes after acceptance do not affect the frame in flight.
  - A held send=1 is re-accepted on the first edge in TX_IDLE. This is the same cycle tx_done is high, so the minimum back-to-back period is frame length + 1 cycle, with 1 idle-high cycle between frames.
- tx_done and ready are registered. There are no combinational paths from inputs to outputs.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - TX_PARITY state present; even parity bit = XOR of the 8 latched data bits.
  - Frame = 11 bits; matches uart_rx with its parity stage active.
- Undefined:
  - TX_PARITY unreachable and removed; TX_DATA goes directly to TX_STOP.
  - Frame = 10 bits.

Test Plan:
- Reset: BASE_FREQ=1000, BAUDRATE=100 (counts_per_bit=10). Hold rst=0, then release -> serial_out=1, ready=1, tx_done=0; line stays high with send=0.
- Single byte 0xA5, no parity: pulse send -> line levels per 10-cycle slot are 0,1,0,1,0,0,1,0,1,1; ready=0 throughout; tx_done high 1 cycle at edge 100 after acceptance.
- Parity on (macro defined):
  - 0x07 -> parity slot = 1, frame 110 cycles.
  - 0x03 -> parity slot = 0.
- Back-to-back: send held high with bytes 0x55 then 0xFF -> second start bit begins exactly 1 idle-high cycle after the first stop bit; both frames decode correctly through a uart_rx loopback.
- Ignored request: pulse send with 0x12 mid-frame of 0x34 -> only 0x34 transmitted; no second frame; ready stays 0 until completion.
- Reset mid-frame: assert rst=0 during data bit 3 -> serial_out=1 immediately; no tx_done; next send of 0x81 produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle between a uart_tx and its client.
interface uart_tx_if;
    logic [7:0] parallel_in;
    logic       send;
    logic       ready;
    logic       serial_out;
    logic       tx_done;

    modport master (
        output parallel_in, send,
        input  ready, serial_out, tx_done
    );

    modport slave (
        input  parallel_in, send,
        output ready, serial_out, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART serializer: start, 8 data bits LSB-first, optional even parity, 1 stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit (11-bit frame).
module uart_tx #(
    parameter int BASE_FREQ = 50_000_000,
    parameter int BAUDRATE  = 115_200
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int CPB = BASE_FREQ / BAUDRATE;
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] TERM = CW'(CPB - 1);

    generate
        if (CPB < 2) begin : g_cpb_chk
            $error("uart_tx: BASE_FREQ/BAUDRATE must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_e;

    tx_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shreg;
    logic          r_serial;
    logic          r_ready;
    logic          r_tx_done;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    logic       w_term;
    logic [2:0] w_next_idx;

    assign w_term     = (r_cnt == TERM);
    assign w_next_idx = r_bit_idx + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= TX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_serial  <= 1'b1;
            r_ready   <= 1'b1;
            r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            // Counter restarts at every bit boundary so each slot is exactly CPB cycles.
            if (r_state != TX_IDLE)
                r_cnt <= w_term ? '0 : r_cnt + 1'b1;

            case (r_state)
                TX_IDLE: begin
                    r_serial <= 1'b1;
                    r_ready  <= 1'b1;
                    if (bus.send) begin
                        r_shreg  <= bus.parallel_in;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^bus.parallel_in;
`endif
                        r_serial <= 1'b0;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_state  <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_term) begin
                        r_serial  <= r_shreg[0];
                        r_bit_idx <= 3'd0;
                        r_state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_term) begin
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_serial <= r_parity;
                            r_state  <= TX_PARITY;
`else
                            r_serial <= 1'b1;
                            r_state  <= TX_STOP;
`endif
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_serial  <= r_shreg[w_next_idx];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (w_term) begin
                        r_serial <= 1'b1;
                        r_state  <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_term) begin
                        r_serial  <= 1'b1;
                        r_ready   <= 1'b1;
                        r_tx_done <= 1'b1;
                        r_state   <= TX_IDLE;
                    end
                end
                default: begin
                    r_serial <= 1'b1;
                    r_ready  <= 1'b1;
                    r_cnt    <= '0;
                    r_state  <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.ready      = r_ready;
    assign bus.serial_out = r_serial;
    assign bus.tx_done    = r_tx_done;

    a_ready_idle: assert property (@(posedge clk) disable iff (!rst)
        r_ready == (r_state == TX_IDLE));
    a_done_ready: assert property (@(posedge clk) disable iff (!rst)
        r_tx_done |-> r_ready);
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a monitor checks each line cycle.
module tb_uart_tx;
    localparam int BF  = 1000;
    localparam int BR  = 100;
    localparam int CPB = BF / BR;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } exp_t;
    exp_t q[$];

    uart_tx_if bus();

    uart_tx #(.BASE_FREQ(BF), .BAUDRATE(BR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0h, need %0h", name, cyc, act, exp);
        end
    endtask

    // Frame slot level straight from the line format: 0, d[0..7], [even parity], 1.
    function automatic logic frame_bit(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (NB == 11 && slot == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic run_frame(input exp_t e);
        chk("start_latency", cyc, e.acc);
        for (int c = 0; c < FL; c++) begin
            if (c > 0) @(negedge clk);
            if (!rst) return;
            chk($sformatf("line_%02h_c%0d", e.data, c), {31'd0, bus.serial_out}, {31'd0, frame_bit(e.data, c / CPB)});
            chk("busy_ready", {31'd0, bus.ready}, 32'd0);
            chk("busy_done", {31'd0, bus.tx_done}, 32'd0);
        end
        @(negedge clk);
        if (!rst) return;
        chk("done_pulse", {31'd0, bus.tx_done}, 32'd1);
        chk("done_ready", {31'd0, bus.ready}, 32'd1);
        chk("done_line", {31'd0, bus.serial_out}, 32'd1);
    endtask

    // Monitor
    initial begin
        exp_t e;
        #2;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_line", {31'd0, bus.serial_out}, 32'd1);
                chk("rst_ready", {31'd0, bus.ready}, 32'd1);
                chk("rst_done", {31'd0, bus.tx_done}, 32'd0);
            end else if (bus.serial_out === 1'b0) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_start at cyc %0d: got start bit, need idle line", cyc);
                end else begin
                    e = q.pop_front();
                    run_frame(e);
                end
            end else begin
                chk("idle_ready", {31'd0, bus.ready}, 32'd1);
                chk("idle_done", {31'd0, bus.tx_done}, 32'd0);
                if (q.size() > 0 && cyc > q[0].acc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL start_missing at cyc %0d: got no start, need start at cyc %0d", cyc, q[0].acc);
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input int gap);
        @(negedge clk);
        bus.send        = 1'b1;
        bus.parallel_in = d;
        q.push_back('{d, cyc + 1});
        @(negedge clk);
        bus.send        = 1'b0;
        bus.parallel_in = 8'($urandom);
        repeat (FL + gap) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        logic [7:0] d;
        bus.send        = 1'b0;
        bus.parallel_in = 8'h00;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rel_line", {31'd0, bus.serial_out}, 32'd1);
        chk("rel_ready", {31'd0, bus.ready}, 32'd1);
        chk("rel_done", {31'd0, bus.tx_done}, 32'd0);
        repeat (20) @(negedge clk);

        send_byte(8'hA5, 3);
        send_byte(8'h07, 0);
        send_byte(8'h03, 2);

        // send held across two frames; data swapped right after first acceptance
        @(negedge clk);
        bus.send        = 1'b1;
        bus.parallel_in = 8'h55;
        q.push_back('{8'h55, cyc + 1});
        q.push_back('{8'hFF, cyc + FL + 2});
        @(negedge clk);
        bus.parallel_in = 8'hFF;
        repeat (FL + 1) @(negedge clk);
        bus.send        = 1'b0;
        bus.parallel_in = 8'($urandom);
        repeat (FL + 2) @(negedge clk);

        // request while busy must be dropped
        @(negedge clk);
        bus.send        = 1'b1;
        bus.parallel_in = 8'h34;
        q.push_back('{8'h34, cyc + 1});
        @(negedge clk);
        bus.send = 1'b0;
        repeat (30) @(negedge clk);
        bus.send        = 1'b1;
        bus.parallel_in = 8'h12;
        @(negedge clk);
        bus.send = 1'b0;
        repeat (FL + 5) @(negedge clk);

        // reset during data bit 3
        d = 8'($urandom);
        @(negedge clk);
        bus.send        = 1'b1;
        bus.parallel_in = d;
        q.push_back('{d, cyc + 1});
        @(negedge clk);
        bus.send = 1'b0;
        repeat (43) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_line", {31'd0, bus.serial_out}, 32'd1);
        chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
        chk("midrst_done", {31'd0, bus.tx_done}, 32'd0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        repeat (FL + 5) @(negedge clk);
        send_byte(8'h81, 2);

        for (int i = 0; i < 20; i++)
            send_byte(8'($urandom), int'($urandom_range(0, 4)));

        repeat (20) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        vectors++;
        miscompares++;
        $display("FAIL watchdog at cyc %0d: got no end of stimulus, need completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
